// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch-port, data-port and memory-side signals of mem_arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives grants,
//            read data, valid pulses, memory strobes and stalls)
//   master : environment view (requesters and memory model)
interface mem_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  // data port
  logic          d_ren;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  // memory side
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  // pipeline stalls
  logic          stall_if;
  logic          stall_mem;

  modport slave (
    input  if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// requester and a data-stage requester. Data normally wins; after
// MAX_DATA_RUN data grants that bypassed a waiting fetch, the fetch wins.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mem_arbiter_if.slave: fetch port (if_*), data port (d_*),
//          memory port (mem_*), combinational stalls (stall_if, stall_mem)
module mem_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] MAX_RUN = CW'(MAX_DATA_RUN);
  localparam logic [CW-1:0] RUN_SAT = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // registered outputs and their next values
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] d_rdata_q,   d_rdata_d;
  logic          if_valid_q,  if_valid_d;
  logic          d_valid_q,   d_valid_d;
  logic [CW-1:0] run_cnt_q,   run_cnt_d;

  // grant decision terms, only meaningful in IDLE
  logic data_elig;
  logic fetch_elig;
  logic data_win;
  logic fetch_win;

  // A requester that is in its valid cycle is already served and is not eligible.
  assign data_elig  = (bus.d_ren | bus.d_wen) & ~d_valid_q;
  assign fetch_elig = bus.if_req & ~if_valid_q;
  assign data_win   = data_elig & ((run_cnt_q < MAX_RUN) | ~fetch_elig);
  assign fetch_win  = fetch_elig & ~data_win;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (data_win) begin
          next_state = D_BUSY;
        end else if (fetch_win) begin
          next_state = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (bus.mem_ack) begin
          next_state = IDLE;
        end
      end
      D_BUSY: begin
        if (bus.mem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    run_cnt_d   = run_cnt_q;
    unique case (state)
      IDLE: begin
        if (data_win) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_wen;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          // count only the data grants that bypassed a waiting fetch
          if (fetch_elig) begin
            run_cnt_d = (run_cnt_q == RUN_SAT) ? RUN_SAT : run_cnt_q + CW'(1);
          end else begin
            run_cnt_d = '0;
          end
        end else if (fetch_win) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          run_cnt_d  = '0;
        end
      end
      IF_BUSY: begin
        if (bus.mem_ack) begin
          if_rdata_d = bus.mem_rdata;
          if_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
        end
      end
      D_BUSY: begin
        // mem_we_q remembers read vs write; d_ren/d_wen are not looked at here
        if (bus.mem_ack) begin
          if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
          d_valid_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // Output and run-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;

  // Stalls are combinational so the pipeline freezes in the request cycle.
  assign bus.stall_if  = bus.if_req & ~if_valid_q;
  assign bus.stall_mem = (bus.d_ren | bus.d_wen) & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized requesters, random memory
// latency and random resets, all checked every cycle against a reference model.
module tb_mem_arbiter;
  localparam int unsigned MAXRUN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DATA_RUN(MAXRUN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // who currently owns the memory: 0 nobody, 1 data requester, 2 fetch requester
  int          owner;
  int          run;
  logic        e_req, e_we, e_ifv, e_dv;
  logic [15:0] e_addr, e_wdata, e_ifr, e_dr;

  task automatic model_reset();
    owner = 0; run = 0;
    e_req = 0; e_we = 0; e_ifv = 0; e_dv = 0;
    e_addr = 0; e_wdata = 0; e_ifr = 0; e_dr = 0;
  endtask

  task automatic model_step();
    bit d_want, f_want;
    d_want = (bus.d_ren || bus.d_wen) && !e_dv;
    f_want = bus.if_req && !e_ifv;
    e_dv  = 0;
    e_ifv = 0;
    if (owner == 0) begin
      if (d_want && (run < int'(MAXRUN) || !f_want)) begin
        owner = 1; e_req = 1; e_we = bus.d_wen;
        e_addr = bus.d_addr; e_wdata = bus.d_wdata;
        run = f_want ? ((run + 1 > 7) ? 7 : run + 1) : 0;
      end else if (f_want) begin
        owner = 2; e_req = 1; e_we = 0; e_addr = bus.if_addr; run = 0;
      end
    end else if (bus.mem_ack) begin
      if (owner == 1) begin
        if (!e_we) e_dr = bus.mem_rdata;
        e_dv = 1;
      end else begin
        e_ifr = bus.mem_rdata;
        e_ifv = 1;
      end
      owner = 0; e_req = 0; e_we = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
    #1;
    check("mem_req",   32'(bus.mem_req),   32'(e_req));
    check("mem_we",    32'(bus.mem_we),    32'(e_we));
    check("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
    check("if_valid",  32'(bus.if_valid),  32'(e_ifv));
    check("if_rdata",  32'(bus.if_rdata),  32'(e_ifr));
    check("d_valid",   32'(bus.d_valid),   32'(e_dv));
    check("d_rdata",   32'(bus.d_rdata),   32'(e_dr));
    check("stall_if",  32'(bus.stall_if),  32'(bus.if_req && !e_ifv));
    check("stall_mem", 32'(bus.stall_mem), 32'((bus.d_ren || bus.d_wen) && !e_dv));
  end

  // ---------------- memory responder ----------------
  bit          rand_mode = 0;
  bit          spur      = 0;
  int          fix_delay = 0;
  logic [15:0] fix_rdata = 16'h0000;
  bit          req_seen  = 0;
  int          cnt       = 0;

  always @(negedge clk) begin
    bus.mem_rdata <= rand_mode ? 16'($urandom) : fix_rdata;
    if (!e_req) begin
      req_seen = 0;
      bus.mem_ack <= rand_mode ? 1'($urandom_range(0, 1)) : 1'(spur);
    end else begin
      if (!req_seen) begin
        req_seen = 1;
        cnt = rand_mode ? int'($urandom_range(0, 3)) : fix_delay;
      end
      if (cnt == 0) begin
        bus.mem_ack <= 1'b1;
      end else begin
        bus.mem_ack <= 1'b0;
        cnt--;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic new_data();
    bit wr;
    wr = 1'($urandom_range(0, 1));
    bus.d_wen   = wr;
    bus.d_ren   = !wr;
    bus.d_addr  = 16'($urandom);
    bus.d_wdata = 16'($urandom);
  endtask

  bit d_act, f_act;
  int rst_hold;

  initial begin
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_ren = 0; bus.d_wen = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) tick();
    // reset state
    check("rst_mem_req",  32'(bus.mem_req),  0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_d_valid",  32'(bus.d_valid),  0);
    check("rst_if_rdata", 32'(bus.if_rdata), 0);
    rst = 0; fix_rdata = 16'hBEEF; fix_delay = 0;

    // single fetch, immediate ack
    tick();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    tick();
    check("f_req",   32'(bus.mem_req),  1);
    check("f_addr",  32'(bus.mem_addr), 32'h0010);
    check("f_we",    32'(bus.mem_we),   0);
    check("f_stall", 32'(bus.stall_if), 1);
    tick();
    check("f_valid", 32'(bus.if_valid), 1);
    check("f_rdata", 32'(bus.if_rdata), 32'hBEEF);
    check("f_req_lo", 32'(bus.mem_req), 0);
    bus.if_req = 0;
    tick();
    check("f_valid_1cyc", 32'(bus.if_valid), 0);
    fix_delay = 3;

    // data write with a 3-cycle ack delay
    tick();
    bus.d_wen = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("w_req",   32'(bus.mem_req),   1);
      check("w_we",    32'(bus.mem_we),    1);
      check("w_addr",  32'(bus.mem_addr),  32'h0200);
      check("w_wdata", 32'(bus.mem_wdata), 32'h1234);
      check("w_stall", 32'(bus.stall_mem), 1);
      check("w_noval", 32'(bus.d_valid),   0);
    end
    tick();
    check("w_valid",   32'(bus.d_valid),   1);
    check("w_stall_lo", 32'(bus.stall_mem), 0);
    check("w_rdata_keep", 32'(bus.d_rdata), 0);
    bus.d_wen = 0;
    tick();
    check("w_valid_1cyc", 32'(bus.d_valid), 0);
    fix_delay = 0; fix_rdata = 16'h5A5A;

    // simultaneous requests: data first, gap, then fetch
    tick();
    bus.if_req = 1; bus.if_addr = 16'h0044;
    bus.d_ren = 1; bus.d_addr = 16'h0300;
    tick();
    check("s_first_addr", 32'(bus.mem_addr), 32'h0300);
    check("s_first_req",  32'(bus.mem_req),  1);
    tick();
    check("s_dvalid", 32'(bus.d_valid), 1);
    check("s_drdata", 32'(bus.d_rdata), 32'h5A5A);
    check("s_gap",    32'(bus.mem_req), 0);
    bus.d_ren = 0;
    tick();
    check("s_second_req",  32'(bus.mem_req),  1);
    check("s_second_addr", 32'(bus.mem_addr), 32'h0044);
    tick();
    check("s_ifvalid", 32'(bus.if_valid), 1);
    bus.if_req = 0;
    fix_delay = 5;

    // reset in the middle of a data access, then a stray ack
    tick();
    bus.d_ren = 1; bus.d_addr = 16'h0400;
    tick();
    check("r_req", 32'(bus.mem_req), 1);
    tick();
    rst = 1; spur = 1; fix_delay = 0;
    #1;
    check("r_req_clr",  32'(bus.mem_req),  0);
    check("r_addr_clr", 32'(bus.mem_addr), 0);
    check("r_rd_clr",   32'(bus.d_rdata),  0);
    tick();
    rst = 0;
    check("r_noval", 32'(bus.d_valid), 0);
    tick();
    check("r_regrant",   32'(bus.mem_req),  1);
    check("r_regr_addr", 32'(bus.mem_addr), 32'h0400);
    check("r_noval2",    32'(bus.d_valid),  0);
    spur = 0;
    tick();
    check("r_valid", 32'(bus.d_valid), 1);
    check("r_rdata", 32'(bus.d_rdata), 32'h5A5A);
    bus.d_ren = 0;

    // back-to-back: request held through the valid cycle, new address next
    tick();
    bus.d_ren = 1; bus.d_addr = 16'h0500;
    tick();
    check("b_addr1", 32'(bus.mem_addr), 32'h0500);
    tick();
    check("b_valid", 32'(bus.d_valid), 1);
    tick();
    check("b_nodup", 32'(bus.mem_req), 0);
    bus.d_addr = 16'h0600;
    tick();
    check("b_req2",  32'(bus.mem_req),  1);
    check("b_addr2", 32'(bus.mem_addr), 32'h0600);
    tick();
    bus.d_ren = 0;
    tick();

    // randomized traffic
    rand_mode = 1; d_act = 0; f_act = 0; rst_hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      if (d_act && e_dv) begin
        if ($urandom_range(0, 1) == 1) new_data();
        else begin d_act = 0; bus.d_ren = 0; bus.d_wen = 0; end
      end else if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; new_data();
      end
      if (f_act && e_ifv) begin
        if ($urandom_range(0, 1) == 1) bus.if_addr = 16'($urandom);
        else begin f_act = 0; bus.if_req = 0; end
      end else if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act = 1; bus.if_req = 1; bus.if_addr = 16'($urandom);
      end
      if (rst) begin
        if (rst_hold == 0) rst = 0;
        else rst_hold--;
      end else if ($urandom_range(0, 199) == 0) begin
        rst = 1; rst_hold = int'($urandom_range(0, 1));
      end
    end
    rst = 0;
    bus.if_req = 0; bus.d_ren = 0; bus.d_wen = 0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
